fetchbuffer: RTL
================

# fetchbuffer

Sequential instruction prefetch buffer between the core fetch stage and the instruction port of the memory arbiter. It fetches consecutive words ahead of the core into a small FIFO, serves matching fetches with zero latency, and flushes on a redirect. It presents to the arbiter exactly the `mem_in_type`/`mem_out_type` handshake the core would.

## Interface
- `depth`, default 4: FIFO entries; power of two, 2..16.
- `rst`  in  1: reset, asynchronous, active-low (0 = reset).
- `clk`  in  1: clock, all state on rising edge.
- `fetch_in`  in  mem_in_type: core fetch request. `mem_valid`, `mem_addr` used; `mem_instr`, `mem_wdata`, `mem_wstrb` ignored.
- `fetch_out`  out  mem_out_type: `mem_rdata`, `mem_ready` to core.
- `flush`  in  1: fence.i flush; empty the buffer and stop prefetching.
- `imem_req`  out  mem_in_type: to arbiter instruction port. `mem_instr`=1, `mem_wstrb`=0, `mem_wdata`=0 always.
- `imem_rsp`  in  mem_out_type: from arbiter instruction port.

## Operation
- FIFO entry = {addr[31:0], data[31:0]}. Registers: `pf_addr`, `count`, `outstanding` (0/1), `state`.
- States:
  - IDLE: no prefetch. Entered on reset and on `flush`.
  - FETCH: prefetching from `pf_addr`.
  - DISCARD: one request in flight whose data must be dropped.
- Hit: `fetch_in.mem_valid`=1, `count`>0 and head addr == `fetch_in.mem_addr`.
  - `fetch_out.mem_ready`=1 and `mem_rdata`=head data, combinationally, same cycle. Head is popped.
- Miss: `mem_valid`=1 and not hit. Covers both empty buffer and head mismatch.
  - If `count`>0, or the in-flight address is not `fetch_in.mem_addr`: flush FIFO and set `pf_addr` <= `fetch_in.mem_addr`.
  - Next state is DISCARD if `outstanding`=1, else FETCH.
  - If empty and the in-flight address equals `fetch_in.mem_addr`: no flush, keep waiting.
- Issue rule in FETCH: `imem_req.mem_valid`=1 while `count`+`outstanding` < `depth`. `mem_addr`=`pf_addr` is held stable until `imem_rsp.mem_ready`.
- Response in FETCH: push {`pf_addr`, `imem_rsp.mem_rdata`}, then `pf_addr` += 4, wrapping mod 2^32. Valid stays high with the new address next cycle if space remains.
- Response in DISCARD: data dropped, go to FETCH at the redirected `pf_addr`. No new request is issued while in DISCARD.
- Simultaneous pop and push: `count` unchanged. This is legal when full.
- `flush`=1:
  - Clear FIFO and go to IDLE, or to DISCARD if `outstanding`=1. DISCARD then goes to IDLE, not FETCH.
  - `flush` wins over a same-cycle hit: no `mem_ready` to core.
- Core `mem_valid` in IDLE: treated as a miss, go to FETCH.
- Reset values: `fetch_out` = 0, `imem_req` = 0 except `mem_instr`=1, `count` = 0, `outstanding` = 0, `pf_addr` = 0, state IDLE.
- Reset mid-transaction: all state is cleared immediately. The in-flight response is not awaited; the arbiter is reset in the same domain.

## Timing
- Hit: 0 cycles, combinational ready.
- Miss, no request in flight: `imem_req.mem_valid` rises the cycle after the miss. With memory latency L (ready L cycles after valid), the data is pushed at edge L and delivered to the core the cycle after.
- Miss with a request in flight: add the remaining latency of the discarded request.
- `imem_req` fields are registered. `fetch_out` is combinational from FIFO head and `fetch_in`.
- Steady state with a 1-cycle memory: one word per cycle, no bubbles.

## Configuration
- `FETCHBUFFER_BYPASS_EN` defined:
  - Applies when FIFO is empty, `fetch_in.mem_valid`=1, `imem_rsp.mem_ready`=1 in FETCH, and `pf_addr` == `fetch_in.mem_addr`.
  - `fetch_out` forwards `imem_rsp.mem_rdata` with ready=1 in the same cycle. No push; `pf_addr` still advances.
- Undefined: the response is always pushed and delivered the cycle after, adding one cycle on every miss.

## Structure
- Package `wires`:
  - `fetchbuffer_state_type` enum {IDLE, FETCH, DISCARD}.
  - `fetchbuffer_entry_type` struct {addr, data}.
- Sub-module `fetchbuffer_fifo`:
  - Parameter `depth`; ports push/pop/clear, head output, count output.
  - Same async active-low `rst`.

## Test plan
- Cold start: core fetch 0x100, memory L=2 → `imem_req` addresses 0x100, 0x104, 0x108, 0x10C; core gets 0x100's data 4 cycles after its request (3 with bypass), then 0x104–0x10C at 0-cycle latency.
- Full buffer (`depth`=4), core stalls → `imem_req.mem_valid` drops after 4 responses; a single pop re-enables exactly one request.
- Redirect: head 0x104, core requests 0x200 while 0x110 is in flight → 0x110 response dropped, next request 0x200, no stale data returned.
- Wrap: core fetch 0xFFFFFFFC → next prefetch address 0x00000000.
- `flush` during an outstanding request with a same-cycle hit → no core ready, response discarded, state IDLE, `imem_req.mem_valid`=0 until next core request.
- Assert `rst`=0 mid-request → all outputs 0 (`mem_instr`=1) asynchronously; after release, core fetch 0x0 restarts cleanly.

Source files
------------

// File: rtl/fetchbuffer_pkg.sv
// ============================================================================
// fetchbuffer_pkg (package wires): memory-port handshake and fetchbuffer types
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package wires;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetchbuffer_state_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetchbuffer_entry_type;

  localparam logic [31:0] FB_WORD_STEP = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetchbuffer_fifo.sv
// ============================================================================
// fetchbuffer_fifo: power-of-two FIFO of {addr, data} entries with clear
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetchbuffer_fifo
  import wires::*;
#(
  parameter int depth = 4
) (
  input  logic                         rst,
  input  logic                         clk,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  input  fetchbuffer_entry_type        wdata_i,
  output fetchbuffer_entry_type        head_o,
  output logic [$clog2(depth+1)-1:0]   count_o
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fetchbuffer_entry_type mem_q [depth];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push_i && !pop_i)      count_q <= count_q + CNT_ONE;
      else if (pop_i && !push_i) count_q <= count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetchbuffer.sv
// ============================================================================
// fetchbuffer: sequential instruction prefetch buffer between core and arbiter.
// Optional same-cycle response forwarding: define FETCHBUFFER_BYPASS_EN.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetchbuffer
  import wires::*;
#(
  parameter int depth = 4
) (
  input  logic        rst,
  input  logic        clk,
  input  mem_in_type  fetch_in,
  output mem_out_type fetch_out,
  input  logic        flush,
  output mem_in_type  imem_req,
  input  mem_out_type imem_rsp
);

  localparam int CW = $clog2(depth + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fetchbuffer_state_type state_q, state_d;
  logic [31:0]   pf_addr_q, pf_addr_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          outstanding_q, outstanding_d;
  logic          to_idle_q, to_idle_d;
  logic          fifo_push, fifo_pop, fifo_clear;
  logic [CW-1:0] count, count_d;
  fetchbuffer_entry_type head, push_entry;
  logic          hit, miss, rsp_fire, pending, inflight_match, bypass;
  logic          unused_fetch_bits;

  fetchbuffer_fifo #(.depth(depth)) u_fifo (
    .rst     (rst),
    .clk     (clk),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (fifo_clear),
    .wdata_i (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign unused_fetch_bits = ^{fetch_in.mem_instr, fetch_in.mem_wdata, fetch_in.mem_wstrb};

  assign hit            = fetch_in.mem_valid && (count != '0) && (head.addr == fetch_in.mem_addr);
  assign miss           = fetch_in.mem_valid && !hit;
  assign rsp_fire       = outstanding_q && imem_rsp.mem_ready;
  assign pending        = outstanding_q && !imem_rsp.mem_ready;
  assign inflight_match = outstanding_q && (req_addr_q == fetch_in.mem_addr);
  assign push_entry     = '{addr: pf_addr_q, data: imem_rsp.mem_rdata};

`ifdef FETCHBUFFER_BYPASS_EN
  assign bypass = !flush && (state_q == FETCH) && (count == '0) && fetch_in.mem_valid
                  && rsp_fire && (pf_addr_q == fetch_in.mem_addr);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pf_addr_d  = pf_addr_q;
    to_idle_d  = to_idle_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_clear = 1'b0;
    fetch_out  = '0;

    if (flush) begin
      fifo_clear = 1'b1;
      to_idle_d  = 1'b1;
      state_d    = pending ? DISCARD : IDLE;
    end else if (miss && ((count != '0) || !inflight_match)) begin
      // A response landing this very cycle belongs to the old stream: dropped.
      fifo_clear = 1'b1;
      pf_addr_d  = fetch_in.mem_addr;
      to_idle_d  = 1'b0;
      state_d    = pending ? DISCARD : FETCH;
    end else begin
      if (hit) begin
        fifo_pop            = 1'b1;
        fetch_out.mem_ready = 1'b1;
        fetch_out.mem_rdata = head.data;
      end
      if (rsp_fire) begin
        case (state_q)
          FETCH: begin
            pf_addr_d = pf_addr_q + FB_WORD_STEP;
            if (bypass) begin
              fetch_out.mem_ready = 1'b1;
              fetch_out.mem_rdata = imem_rsp.mem_rdata;
            end else begin
              fifo_push = 1'b1;
            end
          end
          DISCARD: state_d = to_idle_q ? IDLE : FETCH;
          default: ;
        endcase
      end
    end

    count_d = count;
    if (fifo_clear)                  count_d = '0;
    else if (fifo_push && !fifo_pop) count_d = count + CNT_ONE;
    else if (fifo_pop && !fifo_push) count_d = count - CNT_ONE;

    // A pending request keeps its address; otherwise launch at the new pf_addr.
    outstanding_d = pending || ((state_d == FETCH) && (count_d < DEPTH_C));
    req_addr_d    = pending ? req_addr_q : pf_addr_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pf_addr_q     <= '0;
      req_addr_q    <= '0;
      outstanding_q <= 1'b0;
      to_idle_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pf_addr_q     <= pf_addr_d;
      req_addr_q    <= req_addr_d;
      outstanding_q <= outstanding_d;
      to_idle_q     <= to_idle_d;
    end
  end

  always_comb begin
    imem_req           = '0;
    imem_req.mem_instr = 1'b1;
    imem_req.mem_valid = outstanding_q;
    imem_req.mem_addr  = req_addr_q;
  end

endmodule

`default_nettype wire
